rr_arbiter8: RTL and testbench



---
 rtl/rr_arbiter8.sv | 106 ++++++++++
 tb/tb_rr_arbiter8.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/rr_arbiter8.sv
// Round-robin arbiter: one of eight requesters owns the shared resource at a time,
// reported as a 3-bit index plus its one-hot decode, with a bounded hold time.
module rr_arbiter8 #(
  parameter int MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  input  logic       done,
  output logic       gnt_valid,
  output logic [2:0] gnt_idx,
  output logic [7:0] gnt,
  output logic       timeout
);

  localparam int CNT_W = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [2:0]       ptr_q, ptr_d;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [2:0]       gnt_idx_q, gnt_idx_d;
  logic             timeout_q, timeout_d;

  logic       pick_found;
  logic [2:0] pick_idx;
  logic [2:0] cand;
  logic       owner_drop;
  logic       hold_limit;

  // Search starts at ptr and wraps, so the last owner is considered last.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = 3'd0;
    cand       = 3'd0;
    for (int i = 0; i < 8; i++) begin
      cand = ptr_q + 3'(i);
      if (!pick_found && req[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  assign owner_drop = done || !req[gnt_idx_q];
  assign hold_limit = (hold_cnt_q == HOLD_LAST);

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    hold_cnt_d = hold_cnt_q;
    gnt_idx_d  = gnt_idx_q;
    timeout_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          state_d    = ST_GRANT;
          gnt_idx_d  = pick_idx;
          hold_cnt_d = '0;
        end
      end
      ST_GRANT: begin
        if (owner_drop || hold_limit) begin
          // Timeout is only flagged when the owner would otherwise have kept going.
          state_d    = ST_IDLE;
          ptr_d      = gnt_idx_q + 3'd1;
          gnt_idx_d  = 3'd0;
          hold_cnt_d = '0;
          timeout_d  = hold_limit && !owner_drop;
        end else begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d    = ST_IDLE;
        gnt_idx_d  = 3'd0;
        hold_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      ptr_q      <= 3'd0;
      hold_cnt_q <= '0;
      gnt_idx_q  <= 3'd0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      hold_cnt_q <= hold_cnt_d;
      gnt_idx_q  <= gnt_idx_d;
      timeout_q  <= timeout_d;
    end
  end

  assign gnt_valid = (state_q == ST_GRANT);
  assign gnt_idx   = gnt_idx_q;
  assign gnt       = gnt_valid ? (8'b0000_0001 << gnt_idx_q) : 8'b0;
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_rr_arbiter8.sv
// Scoreboard bench for rr_arbiter8: a cycle-level ownership model predicts each
// cycle's outputs into a queue, and a negedge monitor compares them to the DUT.
module tb_rr_arbiter8;

  localparam int MAX_HOLD = 16;

  logic       clk;
  logic       rst;
  logic [7:0] req;
  logic       done;
  logic       gntValid;
  logic [2:0] gntIdx;
  logic [7:0] gnt;
  logic       timeout;

  int nCompared;
  int nMismatch;

  typedef struct packed {
    logic       valid;
    logic [2:0] idx;
    logic [7:0] gnt;
    logic       tmo;
  } exp_t;

  exp_t expQ[$];

  // Reference model: who owns the resource, how many cycles it has held it,
  // and who was served last (the next search starts just after that one).
  int modelOwner;
  int modelHeld;
  int modelLast;

  rr_arbiter8 #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .done     (done),
    .gnt_valid(gntValid),
    .gnt_idx  (gntIdx),
    .gnt      (gnt),
    .timeout  (timeout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Model advances on every rising edge using the inputs that were held
  // across that edge, and queues the outputs expected for the following cycle.
  always @(posedge clk) begin
    exp_t e;
    logic tmo;
    logic byOwner;
    int   cand;
    tmo = 1'b0;
    if (rst) begin
      modelOwner = -1;
      modelHeld  = 0;
      modelLast  = 7;
    end else if (modelOwner < 0) begin
      for (int k = 1; k <= 8; k++) begin
        cand = (modelLast + k) % 8;
        if (modelOwner < 0 && req[cand]) begin
          modelOwner = cand;
          modelHeld  = 1;
        end
      end
    end else begin
      byOwner = done || !req[modelOwner];
      if (byOwner || modelHeld == MAX_HOLD) begin
        tmo        = !byOwner;
        modelLast  = modelOwner;
        modelOwner = -1;
        modelHeld  = 0;
      end else begin
        modelHeld = modelHeld + 1;
      end
    end
    e.valid = (modelOwner >= 0);
    e.idx   = (modelOwner >= 0) ? 3'(modelOwner) : 3'd0;
    e.gnt   = 8'b0;
    if (modelOwner >= 0) e.gnt[modelOwner] = 1'b1;
    e.tmo   = tmo;
    expQ.push_back(e);
  end

  task automatic checkOutput(input exp_t e);
    nCompared++;
    if (gntValid !== e.valid) begin
      nMismatch++;
      $display("[TB] FAIL gnt_valid at %0t: got %b expected %b", $time, gntValid, e.valid);
    end
    nCompared++;
    if (gntIdx !== e.idx) begin
      nMismatch++;
      $display("[TB] FAIL gnt_idx at %0t: got %0d expected %0d", $time, gntIdx, e.idx);
    end
    nCompared++;
    if (gnt !== e.gnt) begin
      nMismatch++;
      $display("[TB] FAIL gnt at %0t: got %b expected %b", $time, gnt, e.gnt);
    end
    nCompared++;
    if (timeout !== e.tmo) begin
      nMismatch++;
      $display("[TB] FAIL timeout at %0t: got %b expected %b", $time, timeout, e.tmo);
    end
  endtask

  // Monitor: whenever the model has queued a prediction, check it mid-cycle.
  always @(negedge clk) begin
    if (expQ.size() > 0) checkOutput(expQ.pop_front());
  end

  // Drive one cycle of inputs, then step past the rising edge.
  task automatic applyStimulus(input logic [7:0] r, input logic d, input logic rs);
    req  = r;
    done = d;
    rst  = rs;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] rndReq;
    nCompared = 0;
    nMismatch = 0;
    modelOwner = -1;
    modelHeld  = 0;
    modelLast  = 7;
    req  = 8'h00;
    done = 1'b0;
    rst  = 1'b1;

    // Reset, single request on line 2, then release with done.
    applyStimulus(8'h00, 1'b0, 1'b1);
    applyStimulus(8'h00, 1'b0, 1'b1);
    applyStimulus(8'h04, 1'b0, 1'b0);
    applyStimulus(8'h04, 1'b0, 1'b0);
    applyStimulus(8'h04, 1'b1, 1'b0);
    applyStimulus(8'h00, 1'b0, 1'b0);

    // Full rotation with every line requesting and done one cycle after grant.
    for (int i = 0; i < 10; i++) begin
      applyStimulus(8'hFF, 1'b0, 1'b0);
      applyStimulus(8'hFF, 1'b1, 1'b0);
    end

    // Wrap-around: serve 5, then 0 and 5 both request; 0 must win.
    applyStimulus(8'h00, 1'b0, 1'b1);
    applyStimulus(8'h20, 1'b0, 1'b0);
    applyStimulus(8'h20, 1'b1, 1'b0);
    applyStimulus(8'h21, 1'b0, 1'b0);
    applyStimulus(8'h21, 1'b1, 1'b0);

    // Single line held with no done: timeout, one idle cycle, regrant.
    for (int i = 0; i < 2 * MAX_HOLD + 6; i++) applyStimulus(8'h80, 1'b0, 1'b0);

    // done on the final allowed cycle is a normal release, not a timeout.
    applyStimulus(8'h00, 1'b0, 1'b0);
    applyStimulus(8'h00, 1'b0, 1'b0);
    applyStimulus(8'h80, 1'b0, 1'b0);
    for (int i = 0; i < MAX_HOLD - 1; i++) applyStimulus(8'h80, 1'b0, 1'b0);
    applyStimulus(8'h80, 1'b1, 1'b0);
    applyStimulus(8'h00, 1'b0, 1'b0);

    // Request drop mid-grant, then done while idle with nothing pending.
    applyStimulus(8'h08, 1'b0, 1'b0);
    applyStimulus(8'h08, 1'b0, 1'b0);
    applyStimulus(8'h00, 1'b0, 1'b0);
    applyStimulus(8'h00, 1'b1, 1'b0);
    applyStimulus(8'h00, 1'b0, 1'b0);

    // Reset while line 5 owns the grant; afterwards line 0 wins.
    applyStimulus(8'h20, 1'b0, 1'b0);
    applyStimulus(8'h20, 1'b0, 1'b0);
    applyStimulus(8'hFF, 1'b0, 1'b1);
    applyStimulus(8'hFF, 1'b1, 1'b1);
    applyStimulus(8'hFF, 1'b0, 1'b0);
    applyStimulus(8'hFF, 1'b1, 1'b0);

    // Random traffic: requests change occasionally so long holds and timeouts occur.
    rndReq = 8'h00;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0)
        rndReq = 8'($urandom_range(0, 255) & $urandom_range(0, 255));
      applyStimulus(rndReq, ($urandom_range(0, 19) == 0), ($urandom_range(0, 199) == 0));
    end
    applyStimulus(8'h00, 1'b0, 1'b0);

    @(negedge clk);
    #2;
    nCompared++;
    if (expQ.size() != 0) begin
      nMismatch++;
      $display("[TB] FAIL drain: got %0d pending predictions expected 0", expQ.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
    $finish;
  end

endmodule
